// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared FSM encodings and register constants for hazard control
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD2_TAIL = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - combinational load-use match of decode sources against one stage
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1 && (rs1 == rd);
  assign rs2_hit = use_rs2 && (rs2 == rd);
  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for
  assign hit     = is_load && (rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall and branch flush sequencing with debug cycle counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_is_load_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             branch_taken_i,
  output logic             stall_from_ld_2clk_o,
  output logic             stall_from_ld_1clk_o,
  output logic             flush_o,
  output logic             pc_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(FLUSH_CYCLES - 1);

  hz_state_t        state, state_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic             hit_ex, hit_mem;
  logic             stall2, stall1, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_match u_match_ex (
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .use_rs1 (id_use_rs1_i),
    .use_rs2 (id_use_rs2_i),
    .rd      (ex_rd_i),
    .is_load (ex_is_load_i),
    .hit     (hit_ex)
  );

  hazard_match u_match_mem (
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .use_rs1 (id_use_rs1_i),
    .use_rs2 (id_use_rs2_i),
    .rd      (mem_rd_i),
    .is_load (mem_is_load_i),
    .hit     (hit_mem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Requests are Mealy; everything is gated by reset so nothing leaks out while rst is low
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    stall2    = 1'b0;
    stall1    = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (branch_taken_i) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = ST_FLUSH;
              rem_nxt   = REM_LOAD;
            end
          end else if (hit_ex) begin
            stall2    = 1'b1;
            state_nxt = ST_LD2_TAIL;
          end else if (hit_mem) begin
            stall1 = 1'b1;
          end
        end
        ST_LD2_TAIL: begin
          state_nxt = ST_IDLE;
          if (branch_taken_i) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = ST_FLUSH;
              rem_nxt   = REM_LOAD;
            end
          end else begin
            stall2 = 1'b1;
          end
        end
        ST_FLUSH: begin
          // Hazards are ignored here: the decode instruction is wrong-path
          flush = 1'b1;
          if (branch_taken_i) begin
            rem_nxt = REM_LOAD;
          end else if (rem == REM_W'(1)) begin
            state_nxt = ST_IDLE;
            rem_nxt   = '0;
          end else begin
            rem_nxt = rem - REM_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall2 || stall1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)            flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_from_ld_2clk_o = stall2;
  assign stall_from_ld_1clk_o = stall1;
  assign flush_o              = flush;
  assign pc_hold_o            = stall2 || stall1;
  assign stall_cnt_o          = stall_cnt;
  assign flush_cnt_o          = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, mem_is_load, branch_taken;
  logic        stall2, stall1, flush, pc_hold;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_rs1_i             (id_rs1),
    .id_rs2_i             (id_rs2),
    .id_use_rs1_i         (id_use_rs1),
    .id_use_rs2_i         (id_use_rs2),
    .ex_is_load_i         (ex_is_load),
    .ex_rd_i              (ex_rd),
    .mem_is_load_i        (mem_is_load),
    .mem_rd_i             (mem_rd),
    .branch_taken_i       (branch_taken),
    .stall_from_ld_2clk_o (stall2),
    .stall_from_ld_1clk_o (stall1),
    .flush_o              (flush),
    .pc_hold_o            (pc_hold),
    .stall_cnt_o          (stall_cnt),
    .flush_cnt_o          (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic exl, input logic [4:0] exrd, input logic meml, input logic [4:0] memrd,
                       input logic br);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_is_load = exl; ex_rd = exrd; mem_is_load = meml; mem_rd = memrd;
    branch_taken = br;
  endtask

  task automatic idle_in();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic expect_req(input string tag, input logic s2, input logic s1, input logic fl, input logic ph);
    #1;
    check({tag, ".stall2"}, {31'd0, stall2}, {31'd0, s2});
    check({tag, ".stall1"}, {31'd0, stall1}, {31'd0, s1});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, ".pc_hold"}, {31'd0, pc_hold}, {31'd0, ph});
  endtask

  task automatic expect_cnt(input string tag, input int sc, input int fc);
    check({tag, ".stall_cnt"}, stall_cnt, 32'(sc));
    check({tag, ".flush_cnt"}, flush_cnt, 32'(fc));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    step();
    expect_req("reset_gate", 0, 0, 0, 0);
    expect_cnt("reset", 0, 0);
    idle_in();
    step();
    rst = 1'b1;
    expect_req("post_reset", 0, 0, 0, 0);
    step();

    // load x5 in EX, decode reads rs1=x5
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    expect_req("ld2_c0", 1, 0, 0, 1);
    step();
    expect_req("ld2_c1", 1, 0, 0, 1);
    step();
    idle_in();
    expect_req("ld2_done", 0, 0, 0, 0);
    expect_cnt("ld2_done", 2, 0);
    step();

    // load x7 in MEM, decode reads rs2=x7
    drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    expect_req("ld1_c0", 0, 1, 0, 1);
    step();
    idle_in();
    expect_req("ld1_done", 0, 0, 0, 0);
    expect_cnt("ld1_done", 3, 0);
    step();

    // x0 and use-flag-low never stall
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    expect_req("x0_load", 0, 0, 0, 0);
    step();
    drive(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    expect_req("use_low", 0, 0, 0, 0);
    step();
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 5'd8, 1'b0);
    expect_req("no_match", 0, 0, 0, 0);
    step();
    // EX hit outranks MEM hit
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0);
    expect_req("ex_over_mem", 1, 0, 0, 1);
    step();
    // branch during LD2_TAIL aborts the stall
    branch_taken = 1'b1;
    expect_req("tail_branch", 0, 0, 1, 0);
    step();
    idle_in();
    expect_req("tail_flush2", 0, 0, 1, 0);
    step();
    expect_req("tail_after", 0, 0, 0, 0);
    expect_cnt("tail_after", 4, 2);
    step();

    // simultaneous hit_ex and branch in IDLE
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1);
    expect_req("br_and_hit", 0, 0, 1, 0);
    step();
    idle_in();
    expect_req("br_flush2", 0, 0, 1, 0);
    step();
    expect_req("br_after", 0, 0, 0, 0);
    expect_cnt("br_after", 4, 4);
    step();

    // branch in FLUSH reloads; hazards in FLUSH ignored
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    expect_req("rl_c0", 0, 0, 1, 0);
    step();
    expect_req("rl_c1", 0, 0, 1, 0);
    step();
    drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0);
    expect_req("rl_c2_hit_ignored", 0, 0, 1, 0);
    step();
    idle_in();
    expect_req("rl_after", 0, 0, 0, 0);
    expect_cnt("rl_after", 4, 7);
    step();

    // asynchronous reset mid-flush with remaining==1
    branch_taken = 1'b1;
    expect_req("rst_br", 0, 0, 1, 0);
    step();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    #2;
    rst = 1'b0;
    expect_req("rst_mid_flush", 0, 0, 0, 0);
    expect_cnt("rst_mid_flush", 0, 0);
    step();
    idle_in();
    step();
    rst = 1'b1;
    expect_req("rel_c0", 0, 0, 0, 0);
    step();
    expect_req("rel_c1", 0, 0, 0, 0);
    expect_cnt("rel_c1", 0, 0);
    drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    expect_req("rel_ld1", 0, 1, 0, 1);
    step();
    idle_in();
    expect_cnt("rel_final", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
